// File: rtl/rlbp_readout_seq.sv
// ---------------------------------------------------------------------------
// rlbp_readout_seq
//
// Readout sequencer for the 12-photodiode ring. For every enabled photodiode,
// taken in ascending order, it drives four switch phases: reset, integrate,
// sample-hold and compare. A one-cycle all-zero gap separates each pair of
// phases so that no two switches are ever closed at the same time. On the
// last compare cycle the comparator decision is stored into a shadow
// local-binary-pattern code. That code is published on 'code' together with
// a one-cycle 'done' pulse when the frame completes.
//
// Ports
//   wb_clk_i      sole clock
//   wb_rst_i      synchronous active-high reset (clears code as well)
//   start         one-cycle frame request, ignored unless idle
//   abort         synchronous stop back to idle, code is preserved
//   pd_mask       photodiode enable mask, sampled at start
//   rst_cycles    reset phase length in clocks (0 acts as 1), sampled at start
//   int_cycles    integrate phase length, same rules
//   sh_cycles     sample-hold phase length, same rules
//   cmp_cycles    compare phase length, same rules
//   vref_mode     comparator reference select, sampled at start
//   cmp           comparator decision, already synchronised
//   pd_a          one-hot integrate select
//   pd_b          one-hot reset select
//   sw1           integrator enable
//   sw2           reference select (latched vref_mode while busy)
//   sh_rst        sample-hold reset
//   sh            sample-hold track
//   sh_cmp        compare-phase hold
//   busy          frame in progress
//   done          one-cycle frame-complete pulse
//   code          last completed LBP code
//
// Every output is a register.
// ---------------------------------------------------------------------------
module rlbp_readout_seq #(
    parameter int CNT_W = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start,
    input  logic             abort,
    input  logic [11:0]      pd_mask,
    input  logic [CNT_W-1:0] rst_cycles,
    input  logic [CNT_W-1:0] int_cycles,
    input  logic [CNT_W-1:0] sh_cycles,
    input  logic [CNT_W-1:0] cmp_cycles,
    input  logic             vref_mode,
    input  logic             cmp,
    output logic [11:0]      pd_a,
    output logic [11:0]      pd_b,
    output logic             sw1,
    output logic             sw2,
    output logic             sh_rst,
    output logic             sh,
    output logic             sh_cmp,
    output logic             busy,
    output logic             done,
    output logic [11:0]      code
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        GAP  = 3'd1,
        RST  = 3'd2,
        INT  = 3'd3,
        SH   = 3'd4,
        CMP  = 3'd5,
        DONE = 3'd6
    } state_t;

    // Analog switch bundle, kept together so that a whole phase can be
    // loaded or cleared in one assignment.
    typedef struct packed {
        logic [11:0] pd_a;
        logic [11:0] pd_b;
        logic        sw1;
        logic        sh_rst;
        logic        sh;
        logic        sh_cmp;
    } sw_t;

    localparam sw_t SW_OFF = '0;

    // Lowest set bit of a 12-bit vector. Returns {found, index}.
    function automatic logic [4:0] lowest_set(input logic [11:0] v);
        logic       found;
        logic [3:0] idx;
        found = 1'b0;
        idx   = 4'd0;
        for (int k = 11; k >= 0; k--) begin
            if (v[k]) begin
                found = 1'b1;
                idx   = 4'(k);
            end
        end
        return {found, idx};
    endfunction

    // Switch pattern for a phase, with 'sel' the one-hot photodiode select.
    function automatic sw_t phase_sw(input state_t ph, input logic [11:0] sel);
        sw_t s;
        s = SW_OFF;
        case (ph)
            RST: begin
                s.pd_b   = sel;
                s.sh_rst = 1'b1;
            end
            INT: begin
                s.pd_a = sel;
                s.sw1  = 1'b1;
            end
            SH: begin
                s.pd_a = sel;
                s.sh   = 1'b1;
            end
            CMP: begin
                s.sh_cmp = 1'b1;
            end
            default: s = SW_OFF;
        endcase
        return s;
    endfunction

    // Sequencer state
    state_t            state_reg;
    state_t            tag_reg;       // phase entered once the current gap ends
    logic [3:0]        ptr_reg;       // photodiode being read out
    logic [CNT_W-1:0]  cnt_reg;       // cycles left in the current phase, minus 1
    logic              empty_reg;     // frame started with an empty mask

    // Configuration captured at start
    logic [11:0]       mask_reg;
    logic [CNT_W-1:0]  rst_len_reg;
    logic [CNT_W-1:0]  int_len_reg;
    logic [CNT_W-1:0]  sh_len_reg;
    logic [CNT_W-1:0]  cmp_len_reg;
    logic              vref_reg;

    logic [11:0]       shadow_reg;

    // Output registers
    sw_t               sw_reg;
    logic              sw2_reg;
    logic              busy_reg;
    logic              done_reg;
    logic [11:0]       code_reg;

    // Helper signals
    logic [11:0]       above_mask;    // enabled photodiodes strictly above ptr
    logic [11:0]       shadow_upd;    // shadow code with the live cmp at ptr
    logic [11:0]       ptr_onehot;
    logic [4:0]        next_sel;
    logic [4:0]        first_sel;
    logic [CNT_W-1:0]  tag_len;       // counter load value for the tagged phase
    logic [CNT_W-1:0]  tag_dur;

    for (genvar gi = 0; gi < 12; gi++) begin : g_bits
        assign above_mask[gi] = mask_reg[gi] & (4'(gi) > ptr_reg);
        assign shadow_upd[gi] = (4'(gi) == ptr_reg) ? cmp : shadow_reg[gi];
        assign ptr_onehot[gi] = (4'(gi) == ptr_reg);
    end

    assign next_sel  = lowest_set(above_mask);
    assign first_sel = lowest_set(pd_mask);

    always_comb begin
        tag_dur = rst_len_reg;
        case (tag_reg)
            RST:     tag_dur = rst_len_reg;
            INT:     tag_dur = int_len_reg;
            SH:      tag_dur = sh_len_reg;
            CMP:     tag_dur = cmp_len_reg;
            default: tag_dur = rst_len_reg;
        endcase
        // A zero duration behaves as a single cycle.
        tag_len = (tag_dur == '0) ? '0 : tag_dur - CNT_W'(1);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg   <= IDLE;
            tag_reg     <= RST;
            ptr_reg     <= 4'd0;
            cnt_reg     <= '0;
            empty_reg   <= 1'b0;
            mask_reg    <= 12'd0;
            rst_len_reg <= '0;
            int_len_reg <= '0;
            sh_len_reg  <= '0;
            cmp_len_reg <= '0;
            vref_reg    <= 1'b0;
            shadow_reg  <= 12'd0;
            sw_reg      <= SW_OFF;
            sw2_reg     <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            code_reg    <= 12'd0;
        end else if (abort) begin
            // Drop the frame without publishing anything; code is kept.
            state_reg <= IDLE;
            empty_reg <= 1'b0;
            sw_reg    <= SW_OFF;
            sw2_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    sw_reg <= SW_OFF;
                    if (start) begin
                        mask_reg    <= pd_mask;
                        rst_len_reg <= rst_cycles;
                        int_len_reg <= int_cycles;
                        sh_len_reg  <= sh_cycles;
                        cmp_len_reg <= cmp_cycles;
                        vref_reg    <= vref_mode;
                        shadow_reg  <= 12'd0;
                        if (pd_mask == 12'd0) begin
                            // Nothing to read. DONE is held for one extra
                            // cycle, so the pulse appears one edge later.
                            state_reg <= DONE;
                            empty_reg <= 1'b1;
                        end else begin
                            ptr_reg   <= first_sel[3:0];
                            tag_reg   <= RST;
                            state_reg <= GAP;
                            busy_reg  <= 1'b1;
                            sw2_reg   <= vref_mode;
                        end
                    end
                end

                GAP: begin
                    state_reg <= tag_reg;
                    cnt_reg   <= tag_len;
                    sw_reg    <= phase_sw(tag_reg, ptr_onehot);
                end

                RST, INT, SH: begin
                    if (cnt_reg == '0) begin
                        state_reg <= GAP;
                        sw_reg    <= SW_OFF;
                        case (state_reg)
                            RST:     tag_reg <= INT;
                            INT:     tag_reg <= SH;
                            default: tag_reg <= CMP;
                        endcase
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end

                CMP: begin
                    if (cnt_reg == '0) begin
                        // Last compare cycle: this edge captures the decision.
                        shadow_reg <= shadow_upd;
                        sw_reg     <= SW_OFF;
                        if (next_sel[4]) begin
                            ptr_reg   <= next_sel[3:0];
                            tag_reg   <= RST;
                            state_reg <= GAP;
                        end else begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                            code_reg  <= shadow_upd;
                            busy_reg  <= 1'b0;
                            sw2_reg   <= 1'b0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end

                DONE: begin
                    sw_reg <= SW_OFF;
                    if (empty_reg) begin
                        empty_reg <= 1'b0;
                        done_reg  <= 1'b1;
                        code_reg  <= shadow_reg;
                    end else begin
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    sw_reg    <= SW_OFF;
                    busy_reg  <= 1'b0;
                    sw2_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign pd_a   = sw_reg.pd_a;
    assign pd_b   = sw_reg.pd_b;
    assign sw1    = sw_reg.sw1;
    assign sh_rst = sw_reg.sh_rst;
    assign sh     = sw_reg.sh;
    assign sh_cmp = sw_reg.sh_cmp;
    assign sw2    = sw2_reg;
    assign busy   = busy_reg;
    assign done   = done_reg;
    assign code   = code_reg;

endmodule

// File: tb/tb_rlbp_readout_seq.sv
// ---------------------------------------------------------------------------
// tb_rlbp_readout_seq
//
// Table-driven bench for the photodiode readout sequencer. Each table record
// holds one frame configuration along with its hand-computed code and
// start-to-done latency. A timeline model gives the expected switch outputs
// for every cycle of the frame. Hand-written sequences cover reset, abort
// mid-frame and start during a frame.
// ---------------------------------------------------------------------------
module tb_rlbp_readout_seq;

    logic        clk = 1'b0;
    logic        wb_rst_i;
    logic        start;
    logic        abort;
    logic [11:0] pd_mask;
    logic [7:0]  rst_cycles, int_cycles, sh_cycles, cmp_cycles;
    logic        vref_mode;
    logic        cmp;
    logic [11:0] pd_a, pd_b;
    logic        sw1, sw2, sh_rst, sh, sh_cmp, busy, done;
    logic [11:0] code;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rlbp_readout_seq #(.CNT_W(8)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (wb_rst_i),
        .start      (start),
        .abort      (abort),
        .pd_mask    (pd_mask),
        .rst_cycles (rst_cycles),
        .int_cycles (int_cycles),
        .sh_cycles  (sh_cycles),
        .cmp_cycles (cmp_cycles),
        .vref_mode  (vref_mode),
        .cmp        (cmp),
        .pd_a       (pd_a),
        .pd_b       (pd_b),
        .sw1        (sw1),
        .sw2        (sw2),
        .sh_rst     (sh_rst),
        .sh         (sh),
        .sh_cmp     (sh_cmp),
        .busy       (busy),
        .done       (done),
        .code       (code)
    );

    typedef struct {
        logic [11:0] mask;
        logic [7:0]  r, i, s, c;
        logic [11:0] pat;          // comparator decision per photodiode
        logic        vref;
        logic        late_start;   // pulse start while busy
        logic        start_in_done;// pulse start during the done cycle
        logic [11:0] exp_code;
        int          exp_lat;      // edges from E0 to the done cycle
    } vec_t;

    vec_t vecs [6];

    // Packed view of every output except code.
    function automatic logic [30:0] outs();
        return {pd_a, pd_b, sw1, sw2, sh_rst, sh, sh_cmp, busy, done};
    endfunction

    function automatic int dur(input logic [7:0] d);
        return (d == 8'd0) ? 1 : int'(d);
    endfunction

    function automatic int nth_pd(input logic [11:0] m, input int n);
        int k;
        k = 0;
        for (int b = 0; b < 12; b++) begin
            if (m[b]) begin
                if (k == n) return b;
                k++;
            end
        end
        return 0;
    endfunction

    // Expected outputs in cycle t (t = 0 is the cycle after E0).
    function automatic logic [30:0] model(input vec_t v, input int t);
        int r, i, s, c, per, n, lat, o, pd;
        logic [11:0] a, b;
        logic s1, s2, sr, shh, sc, bz, dn;
        a = '0; b = '0;
        s1 = 0; s2 = 0; sr = 0; shh = 0; sc = 0; bz = 0; dn = 0;
        r = dur(v.r); i = dur(v.i); s = dur(v.s); c = dur(v.c);
        per = 4 + r + i + s + c;
        n = $countones(v.mask);
        lat = (n == 0) ? 1 : n * per;
        if (n > 0 && t < lat) begin
            bz = 1'b1;
            s2 = v.vref;
            o  = t % per;
            pd = nth_pd(v.mask, t / per);
            if (o >= 1 && o <= r) begin
                b[pd] = 1'b1; sr = 1'b1;
            end else if (o >= r + 2 && o <= r + 1 + i) begin
                a[pd] = 1'b1; s1 = 1'b1;
            end else if (o >= r + i + 3 && o <= r + i + 2 + s) begin
                a[pd] = 1'b1; shh = 1'b1;
            end else if (o >= r + i + s + 4) begin
                sc = 1'b1;
            end
        end else if (t == lat) begin
            dn = 1'b1;
        end
        return {a, b, s1, s2, sr, shh, sc, bz, dn};
    endfunction

    // cmp holds the wanted decision only on the final compare cycle of each
    // photodiode and the opposite value otherwise.
    function automatic logic cmp_for(input vec_t v, input int t);
        int per, n, o, pd;
        logic bitv;
        per = 4 + dur(v.r) + dur(v.i) + dur(v.s) + dur(v.c);
        n = $countones(v.mask);
        if (n == 0 || t >= n * per) return 1'b0;
        o = t % per;
        pd = nth_pd(v.mask, t / per);
        bitv = v.pat[pd];
        return (o == per - 1) ? bitv : ~bitv;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_cfg(input vec_t v);
        pd_mask    = v.mask;
        rst_cycles = v.r;
        int_cycles = v.i;
        sh_cycles  = v.s;
        cmp_cycles = v.c;
        vref_mode  = v.vref;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int trace_err, inv_err, done_cnt, done_t, first_t;
        logic [30:0] first_act, first_exp, e;
        logic [11:0] code_seen;
        trace_err = 0; inv_err = 0; done_cnt = 0; done_t = -1; first_t = -1;
        first_act = '0; first_exp = '0; code_seen = '0;
        @(negedge clk);
        set_cfg(v);
        start = 1'b1;
        for (int t = 0; t <= v.exp_lat + 3; t++) begin
            @(negedge clk);
            if (t == 0) start = 1'b0;
            e = model(v, t);
            if (outs() !== e) begin
                trace_err++;
                if (first_t < 0) begin
                    first_t = t; first_act = outs(); first_exp = e;
                end
            end
            if ($countones(pd_a | pd_b) > 1 || $countones({sw1, sh_rst, sh, sh_cmp}) > 1)
                inv_err++;
            if (done === 1'b1) begin
                done_cnt++;
                done_t = t;
            end
            if (t == v.exp_lat) code_seen = code;
            cmp = cmp_for(v, t);
            // Starts that must be ignored: while busy, and during done.
            if (v.late_start && t == 5) begin
                start = 1'b1; pd_mask = 12'h000; rst_cycles = 8'd9;
            end else if (v.start_in_done && t == v.exp_lat) begin
                start = 1'b1; pd_mask = 12'hFFF;
            end else begin
                start = 1'b0; set_cfg(v);
            end
        end
        start = 1'b0;
        if (first_t >= 0)
            $display("FAIL vec%0d trace at t=%0d: got 0x%0h, expected 0x%0h", idx, first_t, first_act, first_exp);
        check($sformatf("vec%0d trace_errors", idx), 32'(trace_err), 32'd0);
        check($sformatf("vec%0d invariant_errors", idx), 32'(inv_err), 32'd0);
        check($sformatf("vec%0d done_count", idx), 32'(done_cnt), 32'd1);
        check($sformatf("vec%0d done_latency", idx), 32'(done_t), 32'(v.exp_lat));
        check($sformatf("vec%0d code_at_done", idx), 32'(code_seen), 32'(v.exp_code));
        check($sformatf("vec%0d code_held", idx), 32'(code), 32'(v.exp_code));
        $display("vec%0d mask=0x%03h dur=%0d/%0d/%0d/%0d code=0x%03h done_t=%0d",
                 idx, v.mask, v.r, v.i, v.s, v.c, code, done_t);
    endtask

    initial begin
        int bad;
        //          mask     r     i     s     c     pat      vref  late  sid   code     lat
        vecs[0] = '{12'h001, 8'd1, 8'd1, 8'd1, 8'd1, 12'hFFF, 1'b0, 1'b0, 1'b0, 12'h001, 8};
        vecs[1] = '{12'hFFF, 8'd3, 8'd5, 8'd2, 8'd1, 12'hA5C, 1'b1, 1'b0, 1'b0, 12'hA5C, 180};
        vecs[2] = '{12'h821, 8'd0, 8'd0, 8'd0, 8'd0, 12'hFFF, 1'b0, 1'b0, 1'b0, 12'h821, 24};
        vecs[3] = '{12'h000, 8'd1, 8'd1, 8'd1, 8'd1, 12'hFFF, 1'b1, 1'b0, 1'b1, 12'h000, 1};
        vecs[4] = '{12'h0F0, 8'd2, 8'd1, 8'd3, 8'd2, 12'h5A5, 1'b1, 1'b1, 1'b0, 12'h0A0, 48};
        vecs[5] = '{12'h400, 8'd0, 8'd2, 8'd0, 8'd3, 12'h400, 1'b0, 1'b0, 1'b1, 12'h400, 11};

        wb_rst_i = 1'b1; start = 1'b0; abort = 1'b0; cmp = 1'b0;
        pd_mask = '0; rst_cycles = '0; int_cycles = '0; sh_cycles = '0; cmp_cycles = '0;
        vref_mode = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outputs", {1'b0, outs()}, 32'd0);
        check("reset code", {20'd0, code}, 32'd0);
        wb_rst_i = 1'b0;

        for (int k = 0; k < 6; k++) run_vec(k, vecs[k]);

        // Abort during INT of photodiode 3 (mask 0xFFF, unit durations:
        // 8 cycles per photodiode, INT of slot 3 is cycle 27).
        @(negedge clk);
        pd_mask = 12'hFFF; rst_cycles = 8'd1; int_cycles = 8'd1;
        sh_cycles = 8'd1; cmp_cycles = 8'd1; vref_mode = 1'b1; start = 1'b1;
        for (int t = 0; t < 27; t++) begin
            @(negedge clk);
            start = (t == 10);   // start while busy must be ignored
        end
        @(negedge clk);          // cycle 27
        check("abort pre INT pd3", {19'd0, pd_a, sw1}, {19'd0, 12'h008, 1'b1});
        abort = 1'b1;
        @(negedge clk);          // cycle 28
        abort = 1'b0;
        check("abort outputs idle", {1'b0, outs()}, 32'd0);
        bad = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("abort no done/busy", 32'(bad), 32'd0);
        check("abort code kept", {20'd0, code}, {20'd0, 12'h400});
        $display("abort seq code=0x%03h", code);

        // Reset mid-frame, held for two cycles.
        @(negedge clk);
        pd_mask = 12'h003; start = 1'b1; cmp = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre-reset busy", {31'd0, busy}, 32'd1);
        wb_rst_i = 1'b1;
        @(negedge clk);
        check("reset mid-frame outputs", {1'b0, outs()}, 32'd0);
        check("reset mid-frame code", {20'd0, code}, 32'd0);
        @(negedge clk);
        wb_rst_i = 1'b0;
        check("reset 2nd cycle outputs", {1'b0, outs()}, 32'd0);
        bad = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("reset no done/busy", 32'(bad), 32'd0);
        $display("reset seq code=0x%03h", code);

        // A frame after reset still completes normally.
        run_vec(6, vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
